// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;

    localparam seg_t DIGIT_TAB [0:9] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

endpackage

// File: rtl/seg_scan_bcd_to_seg.sv
// Nibble to active-low segment decoder.
// Nibbles above 9 are not BCD and render as a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);

    // Table lookup for 0-9, dash for invalid BCD.
    always_comb begin
        seg_o = SEG_DASH;
        unique case (nib_i)
            4'd0:    seg_o = DIGIT_TAB[0];
            4'd1:    seg_o = DIGIT_TAB[1];
            4'd2:    seg_o = DIGIT_TAB[2];
            4'd3:    seg_o = DIGIT_TAB[3];
            4'd4:    seg_o = DIGIT_TAB[4];
            4'd5:    seg_o = DIGIT_TAB[5];
            4'd6:    seg_o = DIGIT_TAB[6];
            4'd7:    seg_o = DIGIT_TAB[7];
            4'd8:    seg_o = DIGIT_TAB[8];
            4'd9:    seg_o = DIGIT_TAB[9];
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-coherent capture.
// Outputs are registered from next-state values so a new frame shows fresh data.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       lzb,
    input  logic [7:0] num,
    input  logic [3:0] dp,
    output logic [6:0] seg,
    output logic       seg_dp,
    output logic [3:0] an,
    output logic       frame
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    num_q, num_d;
    logic [3:0]    dp_q, dp_d;
    logic          en_q;
    logic [3:0]    an_q, an_d;
    seg_t          seg_q, seg_d;
    logic          sdp_q, sdp_d;
    logic          frame_q;

    logic          tc;
    logic          load;
    logic [3:0]    nib_sel;
    seg_t          dec_seg;

    assign tc   = (cnt_q == CW'(SCAN_DIV - 1));
    assign load = en & (~en_q | (tc & (idx_q == 2'd3)));

    assign num_d = load ? num : num_q;
    assign dp_d  = load ? dp  : dp_q;

    assign nib_sel = idx_d[0] ? num_d[7:4] : num_d[3:0];

    bcd_to_seg u_dec (
        .nib_i (nib_sel),
        .seg_o (dec_seg)
    );

    // Prescaler and digit index; both parked at zero while disabled.
    always_comb begin
        cnt_d = '0;
        idx_d = 2'd0;
        if (en) begin
            cnt_d = tc ? '0 : cnt_q + CW'(1);
            idx_d = tc ? idx_q + 2'd1 : idx_q;
        end
    end

    // Next display outputs from next-state index and shadow values.
    always_comb begin
        an_d  = 4'hF;
        seg_d = SEG_BLANK;
        sdp_d = 1'b1;
        if (en) begin
            an_d  = ~(4'b0001 << idx_d);
            sdp_d = ~dp_d[idx_d];
            if (idx_d[1]) begin
                seg_d = SEG_BLANK;
            end else if (idx_d[0] && lzb && (num_d[7:4] == 4'd0)) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = dec_seg;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            num_q   <= 8'h00;
            dp_q    <= 4'h0;
            en_q    <= 1'b0;
            an_q    <= 4'hF;
            seg_q   <= SEG_BLANK;
            sdp_q   <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            dp_q    <= dp_d;
            en_q    <= en;
            an_q    <= an_d;
            seg_q   <= seg_d;
            sdp_q   <= sdp_d;
            frame_q <= load;
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign seg_dp = sdp_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with SCAN_DIV=4.
// Reference tracks a position within a 4*DIV-cycle frame.
module tb_seg_scan;

    localparam int DIV = 4;
    localparam int FR  = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       lzb = 1'b0;
    logic [7:0] num = 8'h00;
    logic [3:0] dp  = 4'h0;
    logic [6:0] seg;
    logic       seg_dp;
    logic [3:0] an;
    logic       frame;

    int errors = 0;
    int checks = 0;

    seg_scan #(.SCAN_DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .lzb    (lzb),
        .num    (num),
        .dp     (dp),
        .seg    (seg),
        .seg_dp (seg_dp),
        .an     (an),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_dec(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Reference model state
    int         m_pos = 0;
    logic       m_end = 1'b0;
    logic [7:0] m_num = 8'h00;
    logic [3:0] m_dpv = 4'h0;
    logic [3:0] e_an  = 4'hF;
    logic [6:0] e_seg = 7'h7F;
    logic       e_dp  = 1'b1;
    logic       e_fr  = 1'b0;

    logic       m_ld;
    int         m_np;
    int         m_dig;
    logic [7:0] m_nn;
    logic [3:0] m_nd;
    logic [3:0] n_an;
    logic [6:0] n_seg;
    logic       n_dp;

    always_comb begin
        m_ld  = en && (!m_end || m_pos == FR - 1);
        m_np  = en ? (m_pos + 1) % FR : 0;
        m_nn  = m_ld ? num : m_num;
        m_nd  = m_ld ? dp : m_dpv;
        m_dig = m_np / DIV;
        n_an  = 4'hF;
        n_seg = 7'h7F;
        n_dp  = 1'b1;
        if (en) begin
            n_an = 4'hF;
            n_an[m_dig] = 1'b0;
            n_dp = !m_nd[m_dig];
            if (m_dig == 0)
                n_seg = ref_dec(m_nn[3:0]);
            else if (m_dig == 1)
                n_seg = (lzb && m_nn[7:4] == 4'd0) ? 7'h7F : ref_dec(m_nn[7:4]);
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pos <= 0;
            m_end <= 1'b0;
            m_num <= 8'h00;
            m_dpv <= 4'h0;
            e_an  <= 4'hF;
            e_seg <= 7'h7F;
            e_dp  <= 1'b1;
            e_fr  <= 1'b0;
        end else begin
            m_pos <= m_np;
            m_end <= en;
            m_num <= m_nn;
            m_dpv <= m_nd;
            e_an  <= n_an;
            e_seg <= n_seg;
            e_dp  <= n_dp;
            e_fr  <= m_ld;
        end
    end

    task automatic test_reset;
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({an, seg, seg_dp, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_vals got an=%b seg=%b dp=%b fr=%b want 1111 1111111 1 0",
                     an, seg, seg_dp, frame);
        end
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, seg_dp, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL idle_hold cyc=%0d got an=%b seg=%b dp=%b fr=%b want blank",
                         i, an, seg, seg_dp, frame);
            end
        end
    endtask

    task automatic test_basic_scan;
        int nfr;
        int n1;
        num = 8'h99;
        dp  = 4'b0101;
        lzb = 1'b0;
        en  = 1'b1;
        nfr = 0;
        n1  = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            @(negedge clk);
            if (i < FR - 1 && frame) nfr++;
            if (i >= FR && an == 4'b1101) n1++;
            checks++;
            if ({an, seg, seg_dp, frame} !== {e_an, e_seg, e_dp, e_fr}) begin
                errors++;
                $display("FAIL basic_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b",
                         i, an, seg, seg_dp, frame, e_an, e_seg, e_dp, e_fr);
            end
            checks++;
            case (an)
                4'b1110: if ({seg, seg_dp} !== {7'b0010000, 1'b0}) begin
                    errors++;
                    $display("FAIL basic_d0 got seg=%b dp=%b want 0010000 0", seg, seg_dp);
                end
                4'b1101: if ({seg, seg_dp} !== {7'b0010000, 1'b1}) begin
                    errors++;
                    $display("FAIL basic_d1 got seg=%b dp=%b want 0010000 1", seg, seg_dp);
                end
                4'b1011: if ({seg, seg_dp} !== {7'h7F, 1'b0}) begin
                    errors++;
                    $display("FAIL basic_d2 got seg=%b dp=%b want 1111111 0", seg, seg_dp);
                end
                4'b0111: if ({seg, seg_dp} !== {7'h7F, 1'b1}) begin
                    errors++;
                    $display("FAIL basic_d3 got seg=%b dp=%b want 1111111 1", seg, seg_dp);
                end
                default: begin
                    errors++;
                    $display("FAIL basic_an got an=%b want one-cold", an);
                end
            endcase
        end
        checks++;
        if (nfr !== 1) begin
            errors++;
            $display("FAIL basic_frames got %0d want 1", nfr);
        end
        checks++;
        if (n1 !== DIV) begin
            errors++;
            $display("FAIL basic_slot_len got %0d want %0d", n1, DIV);
        end
    endtask

    task automatic test_coherent;
        int i;
        i = 0;
        while (an !== 4'b1101 && i < 40) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        num = 8'h98;
        i = 0;
        while (!frame && i < 40) begin
            @(negedge clk);
            i++;
            checks++;
            if ({an, seg, seg_dp, frame} !== {e_an, e_seg, e_dp, e_fr}) begin
                errors++;
                $display("FAIL coh_model got %b/%b/%b/%b want %b/%b/%b/%b",
                         an, seg, seg_dp, frame, e_an, e_seg, e_dp, e_fr);
            end
            if (!frame && an == 4'b1101) begin
                checks++;
                if (seg !== 7'b0010000) begin
                    errors++;
                    $display("FAIL coh_hold got seg=%b want 0010000", seg);
                end
            end
        end
        checks++;
        if ({frame, an, seg} !== {1'b1, 4'b1110, 7'b0000000}) begin
            errors++;
            $display("FAIL coh_newunits got fr=%b an=%b seg=%b want 1 1110 0000000",
                     frame, an, seg);
        end
    endtask

    task automatic test_digits(input logic [7:0] v, input logic lz,
                               input logic [6:0] w0, input logic [6:0] w1);
        num = v;
        lzb = lz;
        repeat (FR + 2) @(negedge clk);
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, seg_dp, frame} !== {e_an, e_seg, e_dp, e_fr}) begin
                errors++;
                $display("FAIL dig_model v=%h got %b/%b/%b/%b want %b/%b/%b/%b",
                         v, an, seg, seg_dp, frame, e_an, e_seg, e_dp, e_fr);
            end
            if (an == 4'b1110) begin
                checks++;
                if (seg !== w0) begin
                    errors++;
                    $display("FAIL dig0 v=%h lzb=%b got %b want %b", v, lz, seg, w0);
                end
            end
            if (an == 4'b1101) begin
                checks++;
                if (seg !== w1) begin
                    errors++;
                    $display("FAIL dig1 v=%h lzb=%b got %b want %b", v, lz, seg, w1);
                end
            end
        end
    endtask

    task automatic test_disable;
        int i;
        i = 0;
        while (an !== 4'b1011 && i < 40) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (an !== 4'b1011) begin
            errors++;
            $display("FAIL dis_timeout got an=%b want 1011", an);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({an, seg, seg_dp, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL dis_blank got %b/%b/%b/%b want blank", an, seg, seg_dp, frame);
        end
        num = 8'h47;
        dp  = 4'b0001;
        repeat (9) begin
            @(negedge clk);
            checks++;
            if ({an, frame} !== {4'hF, 1'b0}) begin
                errors++;
                $display("FAIL dis_hold got an=%b fr=%b want 1111 0", an, frame);
            end
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if ({frame, an, seg, seg_dp} !== {1'b1, 4'b1110, 7'b1111000, 1'b0}) begin
            errors++;
            $display("FAIL dis_restart got fr=%b an=%b seg=%b dp=%b want 1 1110 1111000 0",
                     frame, an, seg, seg_dp);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) en = ~en;
            num = 8'($urandom);
            dp  = 4'($urandom);
            lzb = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({an, seg, seg_dp, frame} !== {e_an, e_seg, e_dp, e_fr}) begin
                errors++;
                $display("FAIL rand_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b",
                         i, an, seg, seg_dp, frame, e_an, e_seg, e_dp, e_fr);
            end
        end
    endtask

    task automatic test_reset_mid;
        int i;
        en  = 1'b1;
        num = 8'h26;
        i = 0;
        while (an !== 4'b1011 && i < 40) begin
            @(negedge clk);
            i++;
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({an, seg, seg_dp, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid got %b/%b/%b/%b want blank", an, seg, seg_dp, frame);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({frame, an, seg} !== {1'b1, 4'b1110, 7'b0000010}) begin
            errors++;
            $display("FAIL rst_recap got fr=%b an=%b seg=%b want 1 1110 0000010",
                     frame, an, seg);
        end
        for (int k = 0; k < FR; k++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, seg_dp, frame} !== {e_an, e_seg, e_dp, e_fr}) begin
                errors++;
                $display("FAIL rst_model got %b/%b/%b/%b want %b/%b/%b/%b",
                         an, seg, seg_dp, frame, e_an, e_seg, e_dp, e_fr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_coherent();
        test_digits(8'h05, 1'b1, 7'b0010010, 7'h7F);
        test_digits(8'h05, 1'b0, 7'b0010010, 7'b1000000);
        test_digits(8'hA3, 1'b0, 7'b0110000, 7'b0111111);
        test_disable();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Four-digit multiplexed seven-segment driver that consumes the countdown display interface of the light-controller FSM. It takes the FSM's 2-digit BCD count `num[7:0]` and its 4-bit indicator vector `dp[3:0]` and time-multiplexes them onto a common-anode display.
- Inputs are captured once per scan frame, so a count change never tears mid-frame.
- Sits between the controller FSM and the board's segment/anode pins.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot (50 MHz gives a 1 kHz digit rate and a 250 Hz frame rate). Legal range is ≥2.
- `clk  in  1`: system clock.
- `rst  in  1`: asynchronous, active-low reset.
- `en  in  1`: display power. 0 blanks everything; tie to the power switch.
- `lzb  in  1`: leading-zero blank enable for the tens digit.
- `num  in  8`: BCD count. `[7:4]` is tens, `[3:0]` is units.
- `dp  in  4`: decimal-point indicators; `dp[i]` lights the point of digit i.
- `seg  out  7`: segments `{g,f,e,d,c,b,a}`, active-low.
- `seg_dp  out  1`: decimal point, active-low.
- `an  out  4`: digit anodes, active-low. `an[0]` is the rightmost digit.
- `frame  out  1`: one-cycle pulse marking the clock edge on which inputs were captured.

## Operation
- **Reset values:** `cnt=0`, `idx=0`, shadow `num_s=8'h00`, `dp_s=4'h0`, `an=4'b1111`, `seg=7'h7F`, `seg_dp=1`, `frame=0`.
- **Prescaler:** `cnt` counts `0..SCAN_DIV-1` and wraps. `tc` means `cnt==SCAN_DIV-1`. On `tc`, `idx` advances 0→1→2→3→0 (2-bit wrap).
- **Capture:** `load = (en & ~en_d) | (en & tc & idx==3)`, where `en_d` is `en` registered.
  - On `load`: `num_s<=num`, `dp_s<=dp`, `frame<=1`. Otherwise `frame<=0`.
- **Digit content:**
  - Digit 0: units.
  - Digit 1: tens.
  - Digits 2 and 3: segments always off (`seg=7'h7F`), decimal point still driven.
- **Decode (active-low):**
  - 0=`1000000`, 1=`1111001`, 2=`0100100`, 3=`0110000`, 4=`0011001`, 5=`0010010`, 6=`0000010`, 7=`1111000`, 8=`0000000`, 9=`0010000`.
  - Nibble A–F (invalid BCD) shows a dash, `0111111`.
- **Leading-zero blanking:** if `lzb=1` and `num_s[7:4]==0`, digit 1 shows `7'h7F`. The units digit is never blanked.
- **Decimal point:** `seg_dp = ~dp_s[idx]`.
- **Anodes:** `an = ~(4'b0001 << idx)` while `en=1`.
- **`en=0`:**
  - `cnt` and `idx` are held at 0; the shadow registers are held.
  - `an=4'b1111`, `seg=7'h7F`, `seg_dp=1`, `frame=0`.
- **Reset mid-frame:** all state returns to reset values immediately (asynchronous). No capture occurs until a rising `en` after `rst` deasserts, or until the next frame wrap if `en` is already high.
  - The `en_d` reset value is 0. If `en=1` at reset release, the first cycle therefore counts as a rising `en`, giving an immediate capture.

## Timing
- `an`, `seg`, `seg_dp` and `frame` are registered. They change on the same edge as `idx` and `num_s`.
  - Each output is computed from the next-state values, so digit 0 of a new frame already shows the freshly captured value.
- Each digit stays active for exactly `SCAN_DIV` cycles. A full frame is `4*SCAN_DIV` cycles.
- Input-to-display latency: at most `4*SCAN_DIV+1` cycles. The minimum is 1 cycle, when the input changes on the load cycle.
- Input changes between loads are ignored.
- No dead time between digits; anode and segments switch on the same edge.

## Structure
- Shared package `seg_pkg` holds:
  - the segment constants `SEG_BLANK=7'h7F` and `SEG_DASH=7'h3F`;
  - the 10-entry digit table;
  - the `seg_t` 7-bit typedef.
- One natural sub-module: `bcd_to_seg`, a combinational 4-bit nibble → `seg_t` decoder including the dash case. It is instantiated once, on the mux-selected nibble.
- Top-level `seg_scan` holds the prescaler, index, shadow registers, `en` edge detector and output registers.

## Test plan
Run all scenarios with `SCAN_DIV=4`.
- **Reset/idle:** assert `rst=0` mid-scan → next sample shows `an=1111`, `seg=7F`, `seg_dp=1`. With `en=0` held 40 cycles, outputs stay unchanged and `frame` never pulses.
- **Basic scan:** `en↑`, `num=8'h99`, `dp=4'b0101`, `lzb=0` →
  - `frame` pulses once and `an` sequences `1110,1101,1011,0111` at 4 cycles each.
  - `seg` is `0010000` on digits 0 and 1, and `7F` on digits 2 and 3.
  - `seg_dp` is low on digits 0 and 2.
- **Frame-coherent capture:** change `num` from `8'h99` to `8'h98` in the middle of the digit 1 slot → digit 1 keeps showing 9 until the next `frame`. The new units digit shows `0000000` on the cycle `frame` pulses.
- **Leading-zero blank:** `num=8'h05`, `lzb=1` → digit 1 shows `7F` and digit 0 shows `0010010`. With `lzb=0`, digit 1 shows `1000000`.
- **Invalid BCD:** `num=8'hA3` → digit 1 shows `0111111` and digit 0 shows `0110000`.
- **Disable mid-frame:** drop `en` during the digit 2 slot → next edge gives `an=1111`. Raising `en` again 10 cycles later → immediate `frame` pulse, and the scan restarts at `idx=0` with the current `num`.
